// File: rtl/line_buffer_multi.sv
// line_buffer_multi: multi-line RAM buffer for the vertical scaler.
// Stores the last NUM_LINES video lines in a ring of RAM banks and emits one
// vertical column of NUM_LINES+1 pixels per accepted input pixel, one cycle
// after acceptance.
// Optional build macro LB_EDGE_REPLICATE_EN: produce output from the first
// line of a frame and replicate the oldest filled line into unfilled taps.
module line_buffer_multi #(
   parameter int DATA_WIDTH = 30,
   parameter int ADDR_WIDTH = 6,
   parameter int LINE_WIDTH = 1 << ADDR_WIDTH,
   parameter int NUM_LINES  = 2
) (
   input  logic                                clk,
   input  logic                                i_rst,
   input  logic                                i_sof,
   input  logic                                i_valid,
   input  logic [DATA_WIDTH-1:0]               i_din,
   output logic                                o_valid,
   output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] o_taps,
   output logic [ADDR_WIDTH-1:0]               o_col,
   output logic                                o_eol
);

   localparam int BW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int FW = $clog2(NUM_LINES + 1);
   localparam int TW = (NUM_LINES + 1) * DATA_WIDTH;

   localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(LINE_WIDTH - 1);
   localparam logic [BW-1:0]         LAST_BANK = BW'(NUM_LINES - 1);
   localparam logic [FW-1:0]         FULL      = FW'(NUM_LINES);

   // Bank holding the line written 'age' lines before the current one.
   // The bank at wr_bank holds the oldest line (age NUM_LINES).
   function automatic logic [BW-1:0] bank_of_age(input logic [BW-1:0] wb, input int age);
      int idx;
      idx = (int'(wb) + NUM_LINES - age) % NUM_LINES;
      return BW'(idx);
   endfunction

   logic [DATA_WIDTH-1:0] mem [NUM_LINES][LINE_WIDTH];

   logic [ADDR_WIDTH-1:0] col_cnt;
   logic [BW-1:0]         wr_bank;
   logic [FW-1:0]         fill_cnt;

   logic                  sof_acc;
   logic [ADDR_WIDTH-1:0] col_p0;
   logic [BW-1:0]         bank_p0;
   logic [FW-1:0]         fill_p0;
   logic                  vld_p0;
   logic [TW-1:0]         taps_p0;

   logic [ADDR_WIDTH-1:0] col_nxt;
   logic [BW-1:0]         bank_nxt;
   logic [FW-1:0]         fill_nxt;

   // Acceptance stage: a start-of-frame pixel sees cleared counters.
   always_comb begin
      sof_acc = i_sof & i_valid;
      col_p0  = sof_acc ? '0 : col_cnt;
      bank_p0 = sof_acc ? '0 : wr_bank;
      fill_p0 = sof_acc ? '0 : fill_cnt;
`ifdef LB_EDGE_REPLICATE_EN
      vld_p0  = i_valid;
`else
      vld_p0  = i_valid & (fill_p0 == FULL);
`endif
   end

   // Read-before-write tap assembly from the bank ring.
   always_comb begin
      taps_p0 = '0;
      taps_p0[0 +: DATA_WIDTH] = i_din;
      for (int n = 1; n <= NUM_LINES; n++) begin
`ifdef LB_EDGE_REPLICATE_EN
         int age;
         if (n > int'(fill_p0)) age = int'(fill_p0);
         else                   age = n;
         if (age == 0) taps_p0[n*DATA_WIDTH +: DATA_WIDTH] = i_din;
         else          taps_p0[n*DATA_WIDTH +: DATA_WIDTH] = mem[bank_of_age(bank_p0, age)][col_p0];
`else
         taps_p0[n*DATA_WIDTH +: DATA_WIDTH] = mem[bank_of_age(bank_p0, n)][col_p0];
`endif
      end
   end

   // Column/bank/fill advance for an accepted pixel.
   always_comb begin
      col_nxt  = col_p0 + ADDR_WIDTH'(1);
      bank_nxt = bank_p0;
      fill_nxt = fill_p0;
      if (col_p0 == LAST_COL) begin
         col_nxt  = '0;
         bank_nxt = (bank_p0 == LAST_BANK) ? '0 : bank_p0 + BW'(1);
         fill_nxt = (fill_p0 == FULL) ? fill_p0 : fill_p0 + FW'(1);
      end
   end

   // Line RAM write: current pixel replaces the oldest line at this column.
   always_ff @(posedge clk) begin
      if (i_valid) mem[bank_p0][col_p0] <= i_din;
   end

   // Control state: counters move only on accepted pixels.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         col_cnt  <= '0;
         wr_bank  <= '0;
         fill_cnt <= '0;
      end else if (i_valid) begin
         col_cnt  <= col_nxt;
         wr_bank  <= bank_nxt;
         fill_cnt <= fill_nxt;
      end
   end

   // Output register stage: taps hold when no valid column is produced.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_taps  <= '0;
         o_col   <= '0;
         o_eol   <= 1'b0;
      end else begin
         o_valid <= vld_p0;
         if (vld_p0) begin
            o_taps <= taps_p0;
            o_col  <= col_p0;
            o_eol  <= (col_p0 == LAST_COL);
         end else begin
            o_col  <= '0;
            o_eol  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_multi.sv
// Testbench for line_buffer_multi (LINE_WIDTH=4, NUM_LINES=2).
// Pixel value = frame offset + line*16 + col. Expected columns are queued
// by the driver and checked by an independent monitor on o_valid.
module tb_line_buffer_multi;

   localparam int DW = 16;
   localparam int AW = 2;
   localparam int NL = 2;
   localparam int TW = (NL + 1) * DW;
`ifdef LB_EDGE_REPLICATE_EN
   localparam bit REPL = 1'b1;
`else
   localparam bit REPL = 1'b0;
`endif

   logic          clk;
   logic          i_rst;
   logic          i_sof;
   logic          i_valid;
   logic [DW-1:0] i_din;
   logic          o_valid;
   logic [TW-1:0] o_taps;
   logic [AW-1:0] o_col;
   logic          o_eol;

   line_buffer_multi #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .LINE_WIDTH(4),
      .NUM_LINES (NL)
   ) dut (
      .clk    (clk),
      .i_rst  (i_rst),
      .i_sof  (i_sof),
      .i_valid(i_valid),
      .i_din  (i_din),
      .o_valid(o_valid),
      .o_taps (o_taps),
      .o_col  (o_col),
      .o_eol  (o_eol)
   );

   typedef struct {
      logic [TW-1:0] taps;
      logic [AW-1:0] col;
      logic          eol;
      int            line;
   } exp_t;

   exp_t          q[$];
   int            n_cmp  = 0;
   int            n_fail = 0;
   logic [TW-1:0] last_taps;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pixel seen n lines earlier in the same frame; lines before line 0
   // replicate line 0 when edge replication is built in.
   function automatic logic [DW-1:0] exp_tap(input int off, input int line, input int col, input int n);
      int ln;
      ln = line - n;
      if (REPL && ln < 0) ln = 0;
      return DW'(off + ln * 16 + col);
   endfunction

   function automatic bit exp_vld(input int line);
      return (line >= 2) || REPL;
   endfunction

   task automatic pixel(input bit sof, input int off, input int line, input int col);
      exp_t e;
      @(posedge clk);
      #1;
      i_sof   = sof;
      i_valid = 1'b1;
      i_din   = DW'(off + line * 16 + col);
      if (exp_vld(line)) begin
         e.taps = {exp_tap(off, line, col, 2), exp_tap(off, line, col, 1), exp_tap(off, line, col, 0)};
         e.col  = AW'(col);
         e.eol  = (col == 3);
         e.line = line;
         q.push_back(e);
      end
   endtask

   task automatic line_run(input bit sof, input int off, input int line);
      for (int c = 0; c < 4; c++) pixel(sof && (c == 0), off, line, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         i_valid = 1'b0;
         i_sof   = 1'b0;
      end
   endtask

   // Monitor: pops an expected column for every valid output; otherwise
   // checks that col/eol are zero and taps hold their last value.
   always @(negedge clk) begin
      exp_t e;
      if (i_rst) last_taps = '0;
      if (o_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 64'(o_valid), 64'd0);
         end else begin
            e = q.pop_front();
            chk($sformatf("taps_L%0d_C%0d", e.line, e.col), 64'(o_taps), 64'(e.taps));
            chk($sformatf("col_L%0d_C%0d", e.line, e.col), 64'(o_col), 64'(e.col));
            chk($sformatf("eol_L%0d_C%0d", e.line, e.col), 64'(o_eol), 64'(e.eol));
         end
         last_taps = o_taps;
      end else begin
         chk("idle_outputs", {o_taps, o_col, o_eol}, {last_taps, 2'b00, 1'b0});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      i_rst   = 1'b1;
      i_sof   = 1'b0;
      i_valid = 1'b0;
      i_din   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 64'(o_valid), 64'd0);
      chk("reset_taps",  64'(o_taps),  64'd0);
      chk("reset_col",   64'(o_col),   64'd0);
      chk("reset_eol",   64'(o_eol),   64'd0);
      i_rst = 1'b0;

      // Frame at offset 0: lines 0..3, then line 4 with gaps.
      line_run(1'b1, 0, 0);
      line_run(1'b0, 0, 1);
      line_run(1'b0, 0, 2);
      line_run(1'b0, 0, 3);
      for (int c = 0; c < 4; c++) begin
         pixel(1'b0, 0, 4, c);
         idle(1);
      end
      idle(2);

      // Frame at 0x80 aborted at line 2 col 2 by a new frame at 0x40.
      line_run(1'b1, 'h80, 0);
      line_run(1'b0, 'h80, 1);
      pixel(1'b0, 'h80, 2, 0);
      pixel(1'b0, 'h80, 2, 1);
      line_run(1'b1, 'h40, 0);
      line_run(1'b0, 'h40, 1);
      line_run(1'b0, 'h40, 2);
      idle(2);

      // Frame at 0xC0 interrupted by reset during line 2 col 1.
      line_run(1'b1, 'hC0, 0);
      line_run(1'b0, 'hC0, 1);
      pixel(1'b0, 'hC0, 2, 0);
      @(posedge clk);
      #1;
      i_sof   = 1'b0;
      i_valid = 1'b1;
      i_din   = DW'('hC0 + 2 * 16 + 1);
      @(negedge clk);
      #2;
      i_rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(o_valid), 64'd0);
      chk("async_rst_taps",  64'(o_taps),  64'd0);
      chk("async_rst_col",   64'(o_col),   64'd0);
      chk("async_rst_eol",   64'(o_eol),   64'd0);
      i_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;

      // New frame after reset without i_sof.
      line_run(1'b0, 'h100, 0);
      line_run(1'b0, 'h100, 1);
      line_run(1'b0, 'h100, 2);
      idle(4);

      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/line_buffer_multi.md
Name: line_buffer_multi

Overview:
Parametrised successor to the team's single-port line RAM. It stores the most recent NUM_LINES video lines in NUM_LINES internal RAM banks, used round-robin. It presents a vertical column of NUM_LINES+1 pixels (current plus previous lines) to the downstream scaler, one column per accepted input pixel. Streaming only, no backpressure. Sits between the pixel input stage and the vertical scaler.

Parameters:
DATA_WIDTH, 30, pixel width in bits
ADDR_WIDTH, 6, column address width per bank
LINE_WIDTH, 1<<ADDR_WIDTH, pixels per line; must be <= 2^ADDR_WIDTH and >= 2
NUM_LINES, 2, stored previous lines; output window height is NUM_LINES+1; must be >= 1

Ports:
clk  input  1  clock, rising-edge
i_rst  input  1  asynchronous, active-high reset
i_sof  input  1  start of frame; qualifies the pixel on i_din when i_valid=1
i_valid  input  1  input pixel valid
i_din  input  DATA_WIDTH  input pixel
o_valid  output  1  output column valid
o_taps  output  (NUM_LINES+1)*DATA_WIDTH  tap k at bits [k*DATA_WIDTH +: DATA_WIDTH]; k=0 current line, k=n is n lines earlier
o_col  output  ADDR_WIDTH  column index of the o_taps column
o_eol  output  1  o_taps column is the last column of its line

Behaviour:
- Reset (async, i_rst=1): o_valid=0, o_taps=0, o_col=0, o_eol=0; column counter, bank pointer and filled-line count are cleared to 0. RAM contents are not cleared; they are don't-care until rewritten.
- Banks: NUM_LINES arrays of LINE_WIDTH x DATA_WIDTH. Reads are asynchronous. Writes occur on the clock edge and only when i_valid=1.
- Per accepted pixel (i_valid=1) at column c:
  - Read column c from every bank (read-before-write). The bank at pointer wr_bank holds the oldest line.
  - Register the output, giving 1-cycle latency: tap0 = i_din; tap n = the line n rows older, mapped from the bank ring relative to wr_bank.
  - Write i_din into bank wr_bank at address c.
- Column counter:
  - Increments on each accepted pixel.
  - At LINE_WIDTH-1 it wraps to 0, wr_bank advances modulo NUM_LINES, and the filled-line count increments, saturating at NUM_LINES.
- o_col and o_eol are registered alongside o_taps. o_eol=1 when the column was LINE_WIDTH-1.
- o_valid: registered. Equals i_valid AND (filled-line count == NUM_LINES) at acceptance. When o_valid=0, o_taps keeps its last value and o_col/o_eol are 0.
- i_valid=0: no write, no counter change; o_valid=0 on the next cycle.
- i_sof with i_valid=1:
  - Column counter, wr_bank and filled-line count are forced to 0 before the pixel is processed.
  - The pixel is column 0 of line 0, written to bank 0.
  - Its output is not valid unless the optional feature applies.
- i_sof with i_valid=0: ignored.
- i_sof mid-line: aborts the partial line and restarts as above. No stale tap is marked valid.
- Reset mid-line: all state restarts; the first frame after reset begins at the next pixel even without i_sof.
- Width rules: o_col is zero-extended from the counter. No arithmetic on pixel data.

Optional Feature:
Macro LB_EDGE_REPLICATE_EN.
- Defined:
  - o_valid follows i_valid from the first line of a frame.
  - Taps for lines not yet filled (n > filled-line count) output the oldest filled line's pixel at that column. This is tap (filled-line count), i.e. top-edge replication.
  - On line 0, every tap equals i_din.
- Not defined: behaviour as above; no output until NUM_LINES full lines are stored, and no replication logic is synthesised.

Test Plan:
All scenarios use LINE_WIDTH=4 and NUM_LINES=2, with pixel value = line*16 + col.
1. Reset then frame (i_sof on first pixel, continuous i_valid, 3 lines):
   - o_valid=0 for lines 0-1.
   - Line 2 col 1 gives o_taps = {0x01, 0x11, 0x21} (tap2, tap1, tap0) one cycle after input, with o_col=1.
   - o_eol=1 at col 3.
2. Continue to line 3 (bank wrap): col 0 gives taps {0x10, 0x20, 0x30}. This confirms the round-robin mapping after wr_bank wraps.
3. Gaps (i_valid toggling 1,0,1 on line 2):
   - o_valid pulses only for accepted pixels.
   - The column counter holds across gaps.
   - Taps are identical to scenario 1.
4. i_sof at line 2 col 2:
   - o_valid=0 for the next 8 accepted pixels.
   - The following pixel (new line 2, col 0) gives taps from the new frame only.
5. Assert i_rst mid-line 2, col 1:
   - All outputs go 0 asynchronously.
   - After release, 8 pixels pass with o_valid=0 before the first valid column.
6. With LB_EDGE_REPLICATE_EN:
   - Line 0 col 2 gives taps {0x02, 0x02, 0x02} with o_valid=1.
   - Line 1 col 2 gives taps {0x02, 0x02, 0x12}.
